// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte over open-drain clock/data lines.
// Latency: write accepted in 1 cycle; transfer length is INHIBIT_CYCLES plus 11 device clock periods.
// Backpressure: writes arriving while busy are dropped; optional auto-retry under PS2_TX_RETRY_EN.
module ps2_host_tx #(
    parameter logic [13:0] TX_ADDRESS     = 14'h2501,
    parameter int          INHIBIT_CYCLES = 5000,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic        system_clk,
    input  logic        reset,
    input  logic [13:0] address,
    input  logic        write,
    input  logic        read,
    input  logic [63:0] data_in,
    output logic [63:0] data_out,
    input  logic        PS2_clk_in,
    input  logic        PS2_data_in,
    output logic        PS2_clk_oe,
    output logic        PS2_data_oe,
    output logic        busy
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [IW-1:0] INH_PRE  = IW'(INHIBIT_CYCLES - 2);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_SHIFT,
        S_ACK,
        S_RELEASE
    } state_t;

    state_t        state;
    logic [7:0]    shreg;
    logic          parity;
    logic [3:0]    bitcnt;
    logic [IW-1:0] icnt;
    logic [TW-1:0] tcnt;
    logic          ack_ok;
    logic          error;
`ifdef PS2_TX_RETRY_EN
    logic          retried;
`endif

    logic clk_s1, clk_s2, clk_prev;
    logic data_s1, data_s2;
    logic fe;
    logic accept;
    logic waiting;
    logic release_done;
    logic tmo;
    logic [9:0] frame;
    logic unused_bits;

    // Two-flop synchronisers on both lines plus one history flop for edge detection.
    // Reset to the idle-high level so no false edge is seen after reset.
    always_ff @(posedge system_clk) begin
        if (reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= PS2_clk_in;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= PS2_data_in;
            data_s2  <= data_s1;
        end
    end

    assign fe           = clk_prev & ~clk_s2;
    assign accept       = write && (address == TX_ADDRESS) && (state == S_IDLE);
    assign waiting      = (state == S_START) || (state == S_SHIFT) ||
                          (state == S_ACK)   || (state == S_RELEASE);
    assign release_done = (state == S_RELEASE) && clk_s2 && data_s2;
    assign tmo          = waiting && !fe && !release_done && (tcnt == TMO_LAST);
    // Bits sent after the start bit, in wire order: data LSB first, parity, stop.
    assign frame        = {1'b1, parity, shreg};
    assign unused_bits  = ^data_in[63:8];

    // Status readback; the registers still hold pre-write values during a write cycle.
    assign data_out = (read && (address == TX_ADDRESS)) ? {61'b0, error, ack_ok, busy} : 64'bz;

    // Transfer sequencer with registered line drives and status.
    always_ff @(posedge system_clk) begin
        if (reset) begin
            state       <= S_IDLE;
            shreg       <= 8'h00;
            parity      <= 1'b0;
            bitcnt      <= 4'd0;
            icnt        <= '0;
            tcnt        <= '0;
            PS2_clk_oe  <= 1'b0;
            PS2_data_oe <= 1'b0;
            busy        <= 1'b0;
            ack_ok      <= 1'b0;
            error       <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retried     <= 1'b0;
`endif
        end else if (tmo) begin
`ifdef PS2_TX_RETRY_EN
            if (!retried) begin
                // First failure: go round again with busy still held.
                retried     <= 1'b1;
                state       <= S_INHIBIT;
                icnt        <= '0;
                tcnt        <= '0;
                PS2_clk_oe  <= 1'b1;
                PS2_data_oe <= 1'b0;
            end else
`endif
            begin
                state       <= S_IDLE;
                tcnt        <= '0;
                PS2_clk_oe  <= 1'b0;
                PS2_data_oe <= 1'b0;
                busy        <= 1'b0;
                error       <= 1'b1;
            end
        end else begin
            if (waiting) begin
                tcnt <= fe ? '0 : tcnt + TW'(1);
            end
            case (state)
                S_IDLE: begin
                    PS2_clk_oe  <= 1'b0;
                    PS2_data_oe <= 1'b0;
                    if (accept) begin
                        shreg      <= data_in[7:0];
                        parity     <= ~^data_in[7:0];
                        busy       <= 1'b1;
                        ack_ok     <= 1'b0;
                        error      <= 1'b0;
                        icnt       <= '0;
                        tcnt       <= '0;
                        PS2_clk_oe <= 1'b1;
                        state      <= S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                        retried    <= 1'b0;
`endif
                    end
                end
                S_INHIBIT: begin
                    tcnt <= '0;
                    if (icnt == INH_LAST) begin
                        PS2_clk_oe <= 1'b0;
                        bitcnt     <= 4'd0;
                        state      <= S_START;
                    end else begin
                        icnt <= icnt + IW'(1);
                        // Start bit goes out on the last inhibit cycle.
                        if (icnt == INH_PRE) begin
                            PS2_data_oe <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    if (fe) begin
                        PS2_data_oe <= ~frame[0];
                        bitcnt      <= 4'd1;
                        state       <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (fe) begin
                        PS2_data_oe <= ~frame[bitcnt];
                        bitcnt      <= bitcnt + 4'd1;
                        if (bitcnt == 4'd9) begin
                            state <= S_ACK;
                        end
                    end
                end
                S_ACK: begin
                    PS2_data_oe <= 1'b0;
                    if (fe) begin
                        if (!data_s2) begin
                            ack_ok <= 1'b1;
                            state  <= S_RELEASE;
                        end else begin
`ifdef PS2_TX_RETRY_EN
                            if (!retried) begin
                                retried    <= 1'b1;
                                state      <= S_INHIBIT;
                                icnt       <= '0;
                                tcnt       <= '0;
                                PS2_clk_oe <= 1'b1;
                            end else begin
                                error <= 1'b1;
                                state <= S_RELEASE;
                            end
`else
                            error <= 1'b1;
                            state <= S_RELEASE;
`endif
                        end
                    end
                end
                S_RELEASE: begin
                    PS2_data_oe <= 1'b0;
                    if (release_done) begin
                        busy  <= 1'b0;
                        tcnt  <= '0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    PS2_clk_oe  <= 1'b0;
                    PS2_data_oe <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the CPU to the keyboard over the shared open-drain PS2 clock/data lines.
- Memory-mapped on the 14-bit address / 64-bit data peripheral bus, next to the keyboard receiver.
- The receiver must ignore line activity while this block reports busy.

Parameters:
- TX_ADDRESS, 14'h2501, bus address. Write = send byte; read = status.
- INHIBIT_CYCLES, 5000, system_clk cycles the PS2 clock is held low before start (100 us at 50 MHz).
- TIMEOUT_CYCLES, 100000, maximum system_clk cycles between device clock falling edges before abort.

Ports:
- system_clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- address  in  14  bus address
- write  in  1  write strobe, one cycle
- read  in  1  read enable
- data_in  in  64  write data; bits [7:0] are the byte to send
- data_out  out  64  {61'b0, error, ack_ok, busy} when address==TX_ADDRESS && read; otherwise 64'bz
- PS2_clk_in  in  1  sampled PS2 clock line
- PS2_data_in  in  1  sampled PS2 data line
- PS2_clk_oe  out  1  1 = pull the clock line low
- PS2_data_oe  out  1  1 = pull the data line low
- busy  out  1  transmission in progress

Behaviour:
- Clock and reset: one clock (system_clk); reset is synchronous and active-high.
- Reset values: PS2_clk_oe=0, PS2_data_oe=0, busy=0, ack_ok=0, error=0, state IDLE, all counters 0.
- Reset mid-operation: both lines are released on the clock edge where reset is sampled, and status is cleared.
- Input synchronisation: PS2_clk_in and PS2_data_in pass through 2-flop synchronisers. A falling edge (fe) is prev=1, cur=0 on the synchronised clock, so edge detection has 2-3 cycles of latency.
- Accepting a command: write && address==TX_ADDRESS in IDLE latches data_in[7:0] into shreg and computes parity = ~^byte (odd parity). In the next cycle busy=1, ack_ok=0, error=0.
- Writes while busy are ignored; the byte and status are unchanged.
- Simultaneous read and write: the read returns the pre-write status.
- States:
  - IDLE: lines released. On an accepted write, go to INHIBIT.
  - INHIBIT: PS2_clk_oe=1 for exactly INHIBIT_CYCLES cycles. On the last cycle set PS2_data_oe=1 (start bit 0), then go to START.
  - START: PS2_clk_oe=0, PS2_data_oe stays 1. bitcnt=0. Wait for fe.
  - SHIFT: on each fe, drive the next bit and increment bitcnt.
    - Edges 1-8 drive data bits 0-7, LSB first.
    - Edge 9 drives parity.
    - Edge 10 drives stop = released line.
    - Driving '1' means PS2_data_oe=0; driving '0' means PS2_data_oe=1.
    - After edge 10, go to ACK.
  - ACK: PS2_data_oe=0. On fe, sample synchronised data. Low sets ack_ok=1; high sets error=1 (NACK). Go to RELEASE.
  - RELEASE: wait until synchronised clock and data are both 1, then busy=0 and go to IDLE.
- Timeout: the counter clears on every fe and on state entry. In START, SHIFT, ACK or RELEASE, reaching TIMEOUT_CYCLES releases both lines, sets error=1 and busy=0, and returns to IDLE.
- Status bits ack_ok and error hold until the next accepted write or reset.
- Line exclusion: PS2_clk_oe and PS2_data_oe are never both asserted outside INHIBIT's last cycle, START and SHIFT. PS2_clk_oe=1 only in INHIBIT.

Optional Feature:
- Macro: PS2_TX_RETRY_EN.
- Defined: on NACK or timeout, the block retransmits the same byte automatically, once. It returns to INHIBIT with busy held at 1. error is set only if the retry also fails. A 1-bit retry flag clears on each accepted write.
- Undefined: no retry. The first NACK or timeout sets error and ends the transfer.

Test Plan:
- Write 0xED to 0x2501. Expect clock low 5000 cycles with data low at the last cycle. A device model clocking at 12.5 kHz captures bits 1,0,1,1,0,1,1,1, parity 1, stop 1, then ACKs low. Expect status read = 3'b010 and busy=0.
- Send 0x00 and then 0xFF. Expect parity bits 1 and 0 respectively; both ACKed, status 3'b010.
- NACK: device holds data high at edge 11. Expect error=1, ack_ok=0, status 3'b100, lines released (macro undefined).
- No device clock after start. Expect error=1 at 100000 cycles after START entry, both oe=0, busy=0.
- Write 0x55 at SHIFT edge 4 of a 0xED transfer: ignored, the device captures 0xED. Assert reset at edge 6: both oe=0 the next cycle, status 3'b000.
- With PS2_TX_RETRY_EN: first attempt NACKed, second ACKed. Expect two INHIBIT phases, busy held at 1 throughout, final status 3'b010.
